// File: rtl/risc_pkg.sv
// Shared definitions for the accumulator RISC core: widths, state encodings,
// opcode constants and the decode classes used by the sequencer.
package risc_pkg;

    localparam int DataWidth  = 32;
    localparam int AddrWidth  = 24;
    localparam int OpcodeSize = 8;
    localparam int StateSize  = 2;

    typedef enum logic [StateSize-1:0] {
        Init       = 2'b00,
        InstrFetch = 2'b01,
        InstrExec  = 2'b10
    } stateType;

    localparam logic [OpcodeSize-1:0] OpLda = 8'h00;
    localparam logic [OpcodeSize-1:0] OpSto = 8'h01;
    localparam logic [OpcodeSize-1:0] OpAdd = 8'h02;
    localparam logic [OpcodeSize-1:0] OpSub = 8'h03;
    localparam logic [OpcodeSize-1:0] OpJmp = 8'h04;
    localparam logic [OpcodeSize-1:0] OpJge = 8'h05;
    localparam logic [OpcodeSize-1:0] OpJne = 8'h06;
    localparam logic [OpcodeSize-1:0] OpStp = 8'h07;
    localparam logic [OpcodeSize-1:0] OpShr = 8'h08;
    localparam logic [OpcodeSize-1:0] OpShl = 8'h09;
    localparam logic [OpcodeSize-1:0] OpAnd = 8'h0a;
    localparam logic [OpcodeSize-1:0] OpOr  = 8'h0b;
    localparam logic [OpcodeSize-1:0] OpXor = 8'h0c;
    localparam logic [OpcodeSize-1:0] OpCom = 8'h0d;
    localparam logic [OpcodeSize-1:0] OpSwp = 8'h0e;
    localparam logic [OpcodeSize-1:0] OpNop = 8'h0f;

    localparam logic [DataWidth-1:0] NopInstr = 32'h0F00_0000;

    typedef enum logic [2:0] {
        ClsMemRead,
        ClsMemWrite,
        ClsJump,
        ClsRegOp,
        ClsStop,
        ClsNop
    } opClassType;

    typedef enum logic [1:0] {
        CondAlways,
        CondGe,
        CondNe
    } jumpCondType;

endpackage

// File: rtl/risc_op_decode.sv
// Combinational opcode classifier: collapses the opcode space into the few
// behaviours the sequencer FSM distinguishes, plus the branch condition.
module risc_op_decode
    import risc_pkg::*;
(
    input  logic [OpcodeSize-1:0] opcode,
    output opClassType            opClass,
    output jumpCondType           jumpCond
);

    always_comb begin
        opClass  = ClsNop;
        jumpCond = CondAlways;
        case (opcode)
            OpLda, OpAdd, OpSub, OpAnd, OpOr, OpXor: opClass = ClsMemRead;
            OpSto:                                   opClass = ClsMemWrite;
            OpJmp:                                   opClass = ClsJump;
            OpJge: begin
                opClass  = ClsJump;
                jumpCond = CondGe;
            end
            OpJne: begin
                opClass  = ClsJump;
                jumpCond = CondNe;
            end
            OpShr, OpShl, OpCom, OpSwp:              opClass = ClsRegOp;
            OpStp:                                   opClass = ClsStop;
            default:                                 opClass = ClsNop;
        endcase
    end

endmodule

// File: rtl/risc_sequencer.sv
// Init/Fetch/Exec sequencer with PC, ACC and IR; feeds the ALU and writes its
// results back, and runs the single-outstanding memory request handshake.
module risc_sequencer
    import risc_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DataWidth-1:0]  alu_result,
    input  logic [DataWidth-1:0]  mem_rd_data,
    input  logic                  mem_ack,
    output logic [StateSize-1:0]  current_state,
    output logic [OpcodeSize-1:0] opcode,
    output logic [DataWidth-1:0]  alu_src_a,
    output logic [DataWidth-1:0]  alu_src_b,
    output logic [AddrWidth-1:0]  mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DataWidth-1:0]  mem_wr_data,
    output logic [AddrWidth-1:0]  pc,
    output logic                  halted
);

    stateType              stateReg, stateNext;
    logic [AddrWidth-1:0]  pcReg, pcNext;
    logic [DataWidth-1:0]  accReg, accNext;
    logic [DataWidth-1:0]  irReg, irNext;
    logic                  haltedReg, haltedNext;

    opClassType            opClass;
    jumpCondType           jumpCond;
    logic                  jumpTaken;
    logic [AddrWidth-1:0]  operand;

    assign operand = irReg[AddrWidth-1:0];

    risc_op_decode uDecode (
        .opcode   (irReg[DataWidth-1 -: OpcodeSize]),
        .opClass  (opClass),
        .jumpCond (jumpCond)
    );

    always_comb begin
        case (jumpCond)
            CondGe:  jumpTaken = ~accReg[DataWidth-1];
            CondNe:  jumpTaken = |accReg;
            default: jumpTaken = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateReg  <= Init;
            pcReg     <= '0;
            accReg    <= '0;
            irReg     <= NopInstr;
            haltedReg <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            pcReg     <= pcNext;
            accReg    <= accNext;
            irReg     <= irNext;
            haltedReg <= haltedNext;
        end
    end

    always_comb begin
        stateNext  = stateReg;
        pcNext     = pcReg;
        accNext    = accReg;
        irNext     = irReg;
        haltedNext = haltedReg;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = operand;
        alu_src_b  = {{(DataWidth-AddrWidth){1'b0}}, operand};

        case (stateReg)
            Init: stateNext = InstrFetch;

            InstrFetch: begin
                mem_rd    = 1'b1;
                mem_addr  = pcReg;
                alu_src_b = {{(DataWidth-AddrWidth){1'b0}}, pcReg};
                // The ALU forms PC+1 from alu_src_b during fetch.
                if (mem_ack) begin
                    irNext    = mem_rd_data;
                    pcNext    = alu_result[AddrWidth-1:0];
                    stateNext = InstrExec;
                end
            end

            InstrExec: begin
                case (opClass)
                    ClsMemRead: begin
                        mem_rd    = 1'b1;
                        alu_src_b = mem_rd_data;
                        if (mem_ack) begin
                            accNext   = alu_result;
                            stateNext = InstrFetch;
                        end
                    end
                    ClsMemWrite: begin
                        mem_wr = 1'b1;
                        if (mem_ack) stateNext = InstrFetch;
                    end
                    ClsJump: begin
                        if (jumpTaken) pcNext = operand;
                        stateNext = InstrFetch;
                    end
                    ClsRegOp: begin
                        alu_src_b = accReg;
                        accNext   = alu_result;
                        stateNext = InstrFetch;
                    end
                    ClsStop: haltedNext = 1'b1;
                    default: stateNext = InstrFetch;
                endcase
            end

            default: stateNext = Init;
        endcase
    end

    assign current_state = stateReg;
    assign opcode        = irReg[DataWidth-1 -: OpcodeSize];
    assign alu_src_a     = accReg;
    assign mem_wr_data   = accReg;
    assign pc            = pcReg;
    assign halted        = haltedReg;

endmodule

// File: tb/tb_risc_sequencer.sv
// Bench for risc_sequencer: provides an ALU and a variable-latency memory, and
// checks every instruction against an instruction-level model of the ISA.
module tb_risc_sequencer;

    logic        clock;
    logic        reset;
    logic [31:0] alu_result;
    logic [31:0] mem_rd_data;
    logic        mem_ack;
    logic [1:0]  current_state;
    logic [7:0]  opcode;
    logic [31:0] alu_src_a;
    logic [31:0] alu_src_b;
    logic [23:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_wr_data;
    logic [23:0] pc;
    logic        halted;

    risc_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .alu_result    (alu_result),
        .mem_rd_data   (mem_rd_data),
        .mem_ack       (mem_ack),
        .current_state (current_state),
        .opcode        (opcode),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .mem_addr      (mem_addr),
        .mem_rd        (mem_rd),
        .mem_wr        (mem_wr),
        .mem_wr_data   (mem_wr_data),
        .pc            (pc),
        .halted        (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ALU: increments operand B during fetch, otherwise executes the opcode.
    function automatic logic [31:0] aluModel(input logic [1:0] st, input logic [7:0] op,
                                             input logic [31:0] a, input logic [31:0] b);
        if (st == 2'b01) return b + 32'd1;
        case (op)
            8'h00:   return b;
            8'h02:   return a + b;
            8'h03:   return a - b;
            8'h0a:   return a & b;
            8'h0b:   return a | b;
            8'h0c:   return a ^ b;
            8'h08:   return a >> 1;
            8'h09:   return a << 1;
            8'h0d:   return ~a;
            8'h0e:   return {a[15:0], a[31:16]};
            default: return a;
        endcase
    endfunction

    assign alu_result = aluModel(current_state, opcode, alu_src_a, alu_src_b);

    logic [31:0] mem    [0:255];
    logic [31:0] refMem [0:255];
    logic [23:0] mPc;
    logic [31:0] mAcc;

    int vectors = 0;
    int miscompares = 0;
    int fetchLat = 0;
    int operLat = 0;
    int waitCnt = 0;
    int reqCycles = 0;
    int bothErr = 0;
    int wrCount = 0;
    logic [23:0] lastWrAddr;
    logic [31:0] lastWrData;
    logic [23:0] lastRdAddr;

    // One clock cycle: respond to the request visible now, then advance.
    task automatic tick();
        logic rq, wq, ack, rs;
        logic [23:0] a;
        logic [31:0] wd;
        int lat;
        rq = mem_rd; wq = mem_wr; a = mem_addr; wd = mem_wr_data; rs = reset;
        lat = (current_state == 2'b01) ? fetchLat : operLat;
        if (rq && wq) bothErr++;
        if (rq || wq) begin
            reqCycles++;
            ack = (waitCnt >= lat);
        end else begin
            ack = 1'($urandom_range(0, 1));
        end
        mem_ack = ack;
        mem_rd_data = (rq && ack) ? mem[a[7:0]] : $urandom;
        @(posedge clock);
        if (rs) begin
            waitCnt = 0;
        end else if (rq || wq) begin
            if (ack) begin
                waitCnt = 0;
                if (wq) begin
                    mem[a[7:0]] = wd;
                    wrCount++;
                    lastWrAddr = a;
                    lastWrData = wd;
                end else begin
                    lastRdAddr = a;
                end
            end else begin
                waitCnt++;
            end
        end
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0F00_0000;
            refMem[i] = 32'h0F00_0000;
        end
    endtask

    task automatic load_word(input int addr, input logic [31:0] val);
        mem[addr] = val;
        refMem[addr] = val;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        mPc = '0;
        mAcc = '0;
        tick();
    endtask

    // Run one instruction from the model's PC and compare architectural state.
    task automatic exec_instr(input int fl, input int ol);
        logic [31:0] instr, expAcc;
        logic [7:0]  op;
        logic [23:0] opd, expPc;
        bit isRd, isWr;
        int cyc, expReq;
        instr = refMem[mPc[7:0]];
        op = instr[31:24];
        opd = instr[23:0];
        expPc = mPc + 24'd1;
        expAcc = mAcc;
        isRd = 0;
        isWr = 0;
        case (op)
            8'h00: begin expAcc = refMem[opd[7:0]];        isRd = 1; end
            8'h02: begin expAcc = mAcc + refMem[opd[7:0]]; isRd = 1; end
            8'h03: begin expAcc = mAcc - refMem[opd[7:0]]; isRd = 1; end
            8'h0a: begin expAcc = mAcc & refMem[opd[7:0]]; isRd = 1; end
            8'h0b: begin expAcc = mAcc | refMem[opd[7:0]]; isRd = 1; end
            8'h0c: begin expAcc = mAcc ^ refMem[opd[7:0]]; isRd = 1; end
            8'h01: begin refMem[opd[7:0]] = mAcc;          isWr = 1; end
            8'h04: expPc = opd;
            8'h05: if (!mAcc[31]) expPc = opd;
            8'h06: if (mAcc != 0) expPc = opd;
            8'h08: expAcc = mAcc >> 1;
            8'h09: expAcc = mAcc << 1;
            8'h0d: expAcc = ~mAcc;
            8'h0e: expAcc = {mAcc[15:0], mAcc[31:16]};
            default: ;
        endcase
        fetchLat = fl; operLat = ol; waitCnt = 0;
        reqCycles = 0; bothErr = 0; wrCount = 0;
        cyc = 1 + fl + ((isRd || isWr) ? 1 + ol : 1);
        expReq = 1 + fl + ((isRd || isWr) ? 1 + ol : 0);
        repeat (cyc) tick();
        $display("instr pc=%h ir=%h lat=%0d/%0d -> pc=%h acc=%h", mPc, instr, fl, ol, pc, alu_src_a);
        vectors++;
        if (current_state !== 2'b01) begin
            miscompares++;
            $display("FAIL state_after_instr: got %0h want 1", current_state);
        end
        vectors++;
        if (pc !== expPc) begin
            miscompares++;
            $display("FAIL pc: got %h want %h", pc, expPc);
        end
        vectors++;
        if (alu_src_a !== expAcc) begin
            miscompares++;
            $display("FAIL acc: got %h want %h", alu_src_a, expAcc);
        end
        vectors++;
        if (opcode !== op) begin
            miscompares++;
            $display("FAIL opcode: got %h want %h", opcode, op);
        end
        vectors++;
        if (reqCycles !== expReq) begin
            miscompares++;
            $display("FAIL request_cycles: got %0d want %0d", reqCycles, expReq);
        end
        vectors++;
        if (bothErr !== 0) begin
            miscompares++;
            $display("FAIL rd_wr_overlap: got %0d want 0", bothErr);
        end
        vectors++;
        if (wrCount !== (isWr ? 1 : 0)) begin
            miscompares++;
            $display("FAIL write_count: got %0d want %0d", wrCount, isWr ? 1 : 0);
        end
        if (isWr) begin
            vectors++;
            if (lastWrAddr !== opd || lastWrData !== mAcc) begin
                miscompares++;
                $display("FAIL store: got %h@%h want %h@%h", lastWrData, lastWrAddr, mAcc, opd);
            end
        end
        if (isRd) begin
            vectors++;
            if (lastRdAddr !== opd) begin
                miscompares++;
                $display("FAIL operand_addr: got %h want %h", lastRdAddr, opd);
            end
        end
        vectors++;
        if (halted !== 1'b0) begin
            miscompares++;
            $display("FAIL halted_early: got %b want 0", halted);
        end
        mPc = expPc;
        mAcc = expAcc;
    endtask

    task automatic test_reset();
        clear_mem();
        reset = 1'b1;
        tick();
        tick();
        $display("reset state=%0h pc=%h acc=%h op=%h", current_state, pc, alu_src_a, opcode);
        vectors++;
        if (current_state !== 2'b00 || pc !== 24'h0 || alu_src_a !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_regs: got st=%0h pc=%h acc=%h want 0/0/0", current_state, pc, alu_src_a);
        end
        vectors++;
        if (opcode !== 8'h0f || halted !== 1'b0 || mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got op=%h h=%b rd=%b wr=%b want 0f/0/0/0", opcode, halted, mem_rd, mem_wr);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (current_state !== 2'b01 || mem_rd !== 1'b1 || mem_addr !== 24'h0) begin
            miscompares++;
            $display("FAIL init_to_fetch: got st=%0h rd=%b addr=%h want 1/1/0", current_state, mem_rd, mem_addr);
        end
    endtask

    task automatic test_directed();
        clear_mem();
        load_word(8'h00, 32'h0000_0010);
        load_word(8'h01, 32'h0200_0011);
        load_word(8'h02, 32'h0100_0020);
        load_word(8'h03, 32'h0000_0012);
        load_word(8'h04, 32'h0600_0040);
        load_word(8'h05, 32'h0000_0013);
        load_word(8'h06, 32'h0600_0040);
        load_word(8'h40, 32'h0000_0014);
        load_word(8'h41, 32'h0500_0050);
        load_word(8'h42, 32'h04FF_FFFF);
        load_word(8'h10, 32'd5);
        load_word(8'h11, 32'd7);
        load_word(8'h12, 32'd0);
        load_word(8'h13, 32'd1);
        load_word(8'h14, 32'h8000_0000);
        do_reset();
        exec_instr(0, 0);
        vectors++;
        if (alu_src_a !== 32'd5 || pc !== 24'd1) begin
            miscompares++;
            $display("FAIL lda_zero_wait: got acc=%h pc=%h want 5/1", alu_src_a, pc);
        end
        exec_instr(0, 3);
        vectors++;
        if (alu_src_a !== 32'd12) begin
            miscompares++;
            $display("FAIL add_wait: got %h want 0000000c", alu_src_a);
        end
        exec_instr(0, 0);
        vectors++;
        if (mem[8'h20] !== 32'd12) begin
            miscompares++;
            $display("FAIL sto_mem: got %h want 0000000c", mem[8'h20]);
        end
        exec_instr(1, 0);
        exec_instr(0, 0);
        vectors++;
        if (pc !== 24'h5) begin
            miscompares++;
            $display("FAIL jne_not_taken: got %h want 000005", pc);
        end
        exec_instr(0, 0);
        exec_instr(2, 0);
        vectors++;
        if (pc !== 24'h40) begin
            miscompares++;
            $display("FAIL jne_taken: got %h want 000040", pc);
        end
        exec_instr(0, 1);
        exec_instr(0, 0);
        vectors++;
        if (pc !== 24'h42) begin
            miscompares++;
            $display("FAIL jge_negative: got %h want 000042", pc);
        end
        exec_instr(0, 0);
        exec_instr(0, 0);
        vectors++;
        if (pc !== 24'h0) begin
            miscompares++;
            $display("FAIL pc_wrap: got %h want 000000", pc);
        end
        exec_instr(1, 1);
    endtask

    task automatic test_random();
        logic [7:0] op;
        int pick;
        for (int i = 0; i < 256; i++) begin
            pick = $urandom_range(0, 19);
            if (pick < 16) op = (pick == 7) ? 8'h0f : 8'(pick);
            else op = 8'($urandom_range(16, 255));
            load_word(i, {op, 24'($urandom)});
        end
        do_reset();
        for (int n = 0; n < 150; n++) begin
            exec_instr($urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid_request();
        vectors++;
        if (mem_rd !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_request: got rd=%b want 1", mem_rd);
        end
        fetchLat = 0;
        waitCnt = 0;
        reset = 1'b1;
        tick();
        $display("reset_mid_request state=%0h pc=%h acc=%h op=%h", current_state, pc, alu_src_a, opcode);
        vectors++;
        if (current_state !== 2'b00 || opcode !== 8'h0f || alu_src_a !== 32'h0 || pc !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_mid_request: got st=%0h op=%h acc=%h pc=%h want 0/0f/0/0", current_state, opcode, alu_src_a, pc);
        end
        vectors++;
        if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_drops_request: got rd=%b wr=%b want 0/0", mem_rd, mem_wr);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (current_state !== 2'b01) begin
            miscompares++;
            $display("FAIL restart_fetch: got %0h want 1", current_state);
        end
    endtask

    task automatic test_stop();
        int fl;
        clear_mem();
        load_word(8'h03, 32'h0700_0000);
        do_reset();
        exec_instr(0, 0);
        exec_instr(1, 0);
        exec_instr(0, 0);
        fl = 2;
        fetchLat = fl;
        waitCnt = 0;
        repeat (1 + fl) tick();
        vectors++;
        if (current_state !== 2'b10 || halted !== 1'b0) begin
            miscompares++;
            $display("FAIL stp_first_exec: got st=%0h halted=%b want 2/0", current_state, halted);
        end
        tick();
        vectors++;
        if (halted !== 1'b1) begin
            miscompares++;
            $display("FAIL halted_rise: got %b want 1", halted);
        end
        reqCycles = 0;
        repeat (100) tick();
        $display("stop pc=%h halted=%b requests=%0d", pc, halted, reqCycles);
        vectors++;
        if (reqCycles !== 0) begin
            miscompares++;
            $display("FAIL halted_requests: got %0d want 0", reqCycles);
        end
        vectors++;
        if (pc !== 24'h4 || halted !== 1'b1 || current_state !== 2'b10) begin
            miscompares++;
            $display("FAIL halted_frozen: got pc=%h h=%b st=%0h want 000004/1/2", pc, halted, current_state);
        end
    endtask

    initial begin
        reset = 1'b1;
        mem_ack = 1'b0;
        mem_rd_data = '0;
        @(posedge clock);
        #1;
        test_reset();
        test_directed();
        test_random();
        test_reset_mid_request();
        test_stop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/risc_sequencer.md
# risc_sequencer

Instruction sequencer and register file for the accumulator RISC core, sitting directly upstream and downstream of the ALU. It runs the Init/Fetch/Exec state machine, fetches and holds instructions, and drives the ALU's `CurrentState`, `OpCode`, `ALUSrcA` and `ALUSrcB`. It writes ALU results back into PC and ACC, and handles the memory read/write handshake for instruction and operand traffic.

## Interface
- `DataWidth`, 32: data/instruction width.
- `AddrWidth`, 24: memory address width; equals instruction operand field width.
- `OpcodeSize`, 8: opcode field width, `ir[31:24]`.
- `StateSize`, 2: state encoding width.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `alu_result`  in  DataWidth  `ALUDataOut` from the ALU.
- `mem_rd_data`  in  DataWidth  read data; valid only in a cycle with `mem_ack`=1.
- `mem_ack`  in  1  completes the current `mem_rd`/`mem_wr` at this edge; ignored when no request is active.
- `current_state`  out  StateSize  to the ALU `CurrentState`.
- `opcode`  out  OpcodeSize  to the ALU `OpCode`; equals `ir[31:24]`.
- `alu_src_a`  out  DataWidth  always ACC.
- `alu_src_b`  out  DataWidth  selected B operand; see Operation.
- `mem_addr`  out  AddrWidth  request address.
- `mem_rd`  out  1  read request.
- `mem_wr`  out  1  write request.
- `mem_wr_data`  out  DataWidth  always ACC.
- `pc`  out  AddrWidth  program counter, for debug.
- `halted`  out  1  STP has executed.

## Operation
- States:
  - Init = 2'b00.
  - InstrFetch = 2'b01.
  - InstrExec = 2'b10.
  - 2'b11 is illegal and recovers to Init at the next edge.
- Reset values:
  - state = Init; PC = 0; ACC = 0; IR = 32'h0F00_0000 (NOP).
  - `halted`=0.
  - `mem_rd`=`mem_wr`=0 in Init.
- Init: requests nothing; moves to InstrFetch after one cycle.
- InstrFetch:
  - Drives `mem_rd`=1, `mem_addr`=PC, `alu_src_b`=zero-extended PC.
  - On `mem_ack`: IR <= `mem_rd_data`, PC <= `alu_result[AddrWidth-1:0]` (ALU computes PC+1), next state InstrExec.
  - Without `mem_ack`: holds state and request.
- InstrExec, by opcode, with operand address `ir[23:0]`:
  - LDA/ADD/SUB/AND/OR/XOR (8'h0/2/3/a/b/c):
    - Drives `mem_rd`=1, `mem_addr`=operand, `alu_src_b`=`mem_rd_data`.
    - On `mem_ack`: ACC <= `alu_result`, next state InstrFetch.
  - STO (8'h1): drives `mem_wr`=1, `mem_addr`=operand; on `mem_ack` goes to InstrFetch.
  - JMP (8'h4): PC <= operand.
  - JGE (8'h5): PC <= operand if `ACC[31]`==0, else PC unchanged.
  - JNE (8'h6): PC <= operand if ACC != 0, else PC unchanged.
  - SHR/SHL/COM/SWP (8'h8/9/d/e): `alu_src_b`=ACC; ACC <= `alu_result`.
  - NOP (8'hf) and all undefined opcodes: no register change.
  - JMP/JGE/JNE, SHR/SHL/COM/SWP and NOP/undefined each take one cycle, then InstrFetch.
  - STP (8'h7): `halted` <= 1; remains in InstrExec with no memory request until reset.
- `alu_src_b` defaults to zero-extended operand when not specified above.
- `mem_rd`, `mem_wr`, `mem_addr`, `alu_src_b` are combinational decodes of registered state/IR. They are never asserted together.
- Arithmetic wrap: PC+1 at 24'hFF_FFFF wraps to 0; ACC results are taken modulo 2^32 as produced by the ALU.

## Timing
- Request outputs are valid in the same cycle the state is entered.
- `mem_ack` may arrive in that same cycle (zero-wait) or any later cycle.
- Zero-wait instruction cost:
  - Memory-operand instructions: 2 cycles (Fetch + Exec).
  - Register-only/jump instructions: 2 cycles.
- Each memory wait cycle adds exactly one cycle.
- Reset asserted mid-request: the request drops at the next edge (state = Init); a concurrent `mem_ack` is ignored.
- `halted` rises on the edge that leaves the first STP Exec cycle and stays 1.

## Structure
- Shared package `risc_pkg` holds:
  - Opcode constants LDA..NOP.
  - State encodings Init/InstrFetch/InstrExec.
  - DataWidth/AddrWidth/OpcodeSize.
- The ALU uses `risc_pkg` too.
- One natural sub-module: `risc_op_decode`, combinational. It maps opcode to class (mem_read, mem_write, jump, reg_op, stop, nop) plus jump condition, and keeps the sequencer FSM free of per-opcode case arms.

## Test plan
- Reset then zero-wait memory with `mem[0]`=32'h0000_0010 (LDA 0x10), `mem[0x10]`=5 -> ACC=5 at cycle 3 after reset release, PC=1.
- ADD sequence (LDA 0x10, ADD 0x11) with `mem[0x11]`=7 and `mem_ack` delayed 3 cycles on operand read -> ACC=12; `mem_rd` held steady all 3 wait cycles.
- STO to 0x20 with ACC=12 -> exactly one `mem_wr` cycle with `mem_addr`=0x20 and `mem_wr_data`=12.
- JNE 0x40 with ACC=0 -> PC=next sequential; with ACC=1 -> PC=0x40. JGE with ACC=32'h8000_0000 -> not taken.
- STP fetched at PC=3 -> `halted`=1, no further `mem_rd`/`mem_wr` for 100 cycles, PC=4 frozen.
- Reset pulsed while `mem_rd`=1 and `mem_ack`=1 in the same cycle -> IR remains NOP, state Init, ACC=0, PC=0.
